// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out frame transmitter.
// Frame: start bit (0), DATA_W data bits LSB first, optional even-parity bit,
// stop bit (1). Every bit is held for CLKS_PER_BIT clock cycles.
// Optional feature macro: SERIAL_TX_PARITY_EN adds the parity bit after the data bits.
// Reset is asynchronous and active high; tx idles high.

module serial_tx #(
    parameter int DATA_W       = 8,    // payload width, 1..16
    parameter int CLKS_PER_BIT = 4     // cycles per serial bit, 1..1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    // Counter widths never collapse to zero bits, so CLKS_PER_BIT = 1 and
    // DATA_W = 1 still give legal one-bit counters that stay at zero.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   bit_cnt_reg;
    logic [CNT_W-1:0]   bit_cnt_next;
    logic [IDX_W-1:0]   bit_idx_reg;
    logic [IDX_W-1:0]   bit_idx_next;
    logic [DATA_W-1:0]  shift_reg;
    logic [DATA_W-1:0]  shift_next;
    logic               tx_reg;
    logic               tx_next;

    // Goes high on the first clock edge after reset releases; keeps in_ready
    // low while reset is held and for the remainder of that cycle.
    logic               run_reg;

    logic               accept;
    logic               bit_end;

`ifdef SERIAL_TX_PARITY_EN
    // Even parity of the captured word, frozen at capture time so the shift
    // register can be consumed freely during the data phase.
    logic               parity_reg;
`endif

    // Handshake and status decodes, all derived from registered state.
    assign in_ready = (state_reg == IDLE) && run_reg;
    assign accept   = in_valid && in_ready;
    assign bit_end  = (bit_cnt_reg == CNT_LAST);
    assign busy     = (state_reg != IDLE);
    assign tx_done  = (state_reg == STOP) && bit_end;
    assign tx       = tx_reg;

    // Next-state, counters, shift register and next serial output.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        tx_next      = tx_reg;

        case (state_reg)
            IDLE: begin
                tx_next      = 1'b1;
                bit_cnt_next = '0;
                bit_idx_next = '0;
                if (accept) begin
                    // Start bit appears on the very edge that captures the word.
                    state_next = START;
                    shift_next = in_data;
                    tx_next    = 1'b0;
                end
            end

            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                    bit_idx_next = '0;
                    tx_next      = shift_reg[0];
                    shift_next   = shift_reg >> 1;
                end else begin
                    bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                end
            end

            DATA: begin
                if (bit_end) begin
                    bit_cnt_next = '0;
                    if (bit_idx_reg == IDX_LAST) begin
                        bit_idx_next = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_next   = PARITY;
                        tx_next      = parity_reg;
`else
                        state_next   = STOP;
                        tx_next      = 1'b1;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + IDX_W'(1);
                        tx_next      = shift_reg[0];
                        shift_next   = shift_reg >> 1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                end
            end

`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_next   = STOP;
                    bit_cnt_next = '0;
                    tx_next      = 1'b1;
                end else begin
                    bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                end
            end
`endif

            STOP: begin
                tx_next = 1'b1;
                if (bit_end) begin
                    // Last stop cycle (tx_done is high now); line returns to idle.
                    state_next   = IDLE;
                    bit_cnt_next = '0;
                end else begin
                    bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                end
            end

            default: begin
                state_next   = IDLE;
                bit_cnt_next = '0;
                bit_idx_next = '0;
                tx_next      = 1'b1;
            end
        endcase
    end

    // FSM state, counters, shift register and registered line output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
        end
    end

    // Ready enable: armed by the first clock edge after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_reg <= 1'b0;
        end else begin
            run_reg <= 1'b1;
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    // Parity of the incoming word, latched alongside the capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_reg <= 1'b0;
        end else if (accept) begin
            parity_reg <= ^in_data;
        end
    end
`endif

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed self-checking bench for serial_tx (DATA_W=8, CLKS_PER_BIT=4).
// Honours SERIAL_TX_PARITY_EN the same way the design does.

module tb_serial_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB    = DW + 2 + PAR;    // serial bits per frame
    localparam int FRAME = NB * CPB;        // clock cycles per frame

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] in_data  = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int errors = 0;
    int checks = 0;

    // Per-cycle traces; index i is the value seen after the i-th edge following capture.
    logic [127:0] tx_t;
    logic [127:0] done_t;
    logic [127:0] busy_t;
    logic [127:0] rdy_t;

    serial_tx #(
        .DATA_W      (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .tx      (tx),
        .busy    (busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    // Serial bit order, first-sent bit at index 0: start, data LSB first, [parity], stop.
    function automatic logic [11:0] frame_bits(input logic [7:0] d, input logic p);
`ifdef SERIAL_TX_PARITY_EN
        return {2'b01, p, d, 1'b0};
`else
        return {3'b001, d, 1'b0};
`endif
    endfunction

    // Present a word for exactly the next rising edge; returns half a cycle after it.
    task automatic start_word(input logic [7:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
    endtask

    // Sample the outputs for n cycles (first sample now), optionally pulsing or
    // dropping in_valid after a given sample index. Records only; no comparisons.
    task automatic record(input int n, input int pulse_at, input logic [7:0] pulse_data,
                          input int drop_at);
        tx_t   = '0;
        done_t = '0;
        busy_t = '0;
        rdy_t  = '0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            tx_t[i]   = tx;
            done_t[i] = tx_done;
            busy_t[i] = busy;
            rdy_t[i]  = in_ready;
            if (i == drop_at) in_valid = 1'b0;
            if (pulse_at >= 0 && i == pulse_at) begin
                in_valid = 1'b1;
                in_data  = pulse_data;
            end
            if (pulse_at >= 0 && i == pulse_at + 1) begin
                in_valid = 1'b0;
                in_data  = 8'h00;
            end
        end
    endtask

    task automatic test_reset;
        logic saw_done;
        logic saw_low;
        #40;
        checks++;
        if ({tx, busy, in_ready, tx_done} !== 4'b1000)
            $display("FAIL reset_hold: tx/busy/ready/done=%b expected=1000", {tx, busy, in_ready, tx_done});
        if ({tx, busy, in_ready, tx_done} !== 4'b1000) errors++;
        #40;
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b expected=0 before first edge", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({tx, busy, in_ready} !== 3'b101) begin
            errors++;
            $display("FAIL reset_first_edge: tx/busy/ready=%b expected=101", {tx, busy, in_ready});
        end
        saw_done = 1'b0;
        saw_low  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_done) saw_done = 1'b1;
            if (!tx)     saw_low  = 1'b1;
        end
        checks++;
        if ({saw_done, saw_low} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: saw_done=%b saw_tx_low=%b expected=0,0", saw_done, saw_low);
        end
        $display("test_reset: idle line after reset checked");
    endtask

    task automatic test_single_frame;
        logic [11:0]    seq;
        logic [CPB-1:0] exp_slot;
        logic [127:0]   exp_done;
        logic [127:0]   exp_busy;
        logic [127:0]   exp_rdy;
        seq = frame_bits(8'hA5, 1'b0);
        start_word(8'hA5);
        in_valid = 1'b0;
        record(FRAME + 1, -1, 8'h00, -1);
        for (int b = 0; b < NB; b++) begin
            exp_slot = {CPB{seq[b]}};
            checks++;
            if (tx_t[b*CPB +: CPB] !== exp_slot) begin
                errors++;
                $display("FAIL single_bit%0d: tx=%b expected=%b", b, tx_t[b*CPB +: CPB], exp_slot);
            end
        end
        exp_done = 128'd1 << (FRAME - 1);
        checks++;
        if (done_t !== exp_done) begin
            errors++;
            $display("FAIL single_done: tx_done trace=%h expected=%h", done_t, exp_done);
        end
        exp_busy = (128'd1 << FRAME) - 128'd1;
        checks++;
        if (busy_t !== exp_busy) begin
            errors++;
            $display("FAIL single_busy: busy trace=%h expected=%h", busy_t, exp_busy);
        end
        exp_rdy = 128'd1 << FRAME;
        checks++;
        if (rdy_t !== exp_rdy || tx_t[FRAME] !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: ready trace=%h expected=%h idle_tx=%b", rdy_t, exp_rdy, tx_t[FRAME]);
        end
        $display("test_single_frame: word a5 sent, frame of %0d cycles checked", FRAME);
    endtask

    task automatic test_parity;
        logic [11:0]    seq;
        logic [127:0]   exp_tx;
        logic [127:0]   exp_done;
        logic [CPB-1:0] par_slot;
        seq    = frame_bits(8'h07, 1'b1);
        exp_tx = '0;
        for (int b = 0; b < NB; b++)
            for (int c = 0; c < CPB; c++)
                exp_tx[b*CPB + c] = seq[b];
        exp_tx[FRAME] = 1'b1;
        start_word(8'h07);
        in_valid = 1'b0;
        record(FRAME + 1, -1, 8'h00, -1);
        checks++;
        if (tx_t !== exp_tx) begin
            errors++;
            $display("FAIL parity_frame: tx trace=%h expected=%h", tx_t, exp_tx);
        end
        exp_done = 128'd1 << (FRAME - 1);
        checks++;
        if (done_t !== exp_done) begin
            errors++;
            $display("FAIL parity_len: tx_done trace=%h expected=%h", done_t, exp_done);
        end
`ifdef SERIAL_TX_PARITY_EN
        par_slot = tx_t[(DW+1)*CPB +: CPB];
        checks++;
        if (par_slot !== {CPB{1'b1}}) begin
            errors++;
            $display("FAIL parity_bit: tx=%b expected=%b", par_slot, {CPB{1'b1}});
        end
`else
        par_slot = tx_t[(DW+1)*CPB +: CPB];
        checks++;
        if (par_slot !== {CPB{1'b1}}) begin
            errors++;
            $display("FAIL stop_after_data: tx=%b expected=%b", par_slot, {CPB{1'b1}});
        end
`endif
        $display("test_parity: word 07 sent, frame of %0d cycles checked", FRAME);
    endtask

    task automatic test_back_to_back;
        logic [11:0]  seq_a;
        logic [11:0]  seq_b;
        logic [127:0] exp_tx;
        logic [127:0] exp_done;
        logic [127:0] exp_rdy;
        seq_a  = frame_bits(8'h00, 1'b0);
        seq_b  = frame_bits(8'hFF, 1'b0);
        exp_tx = '0;
        for (int b = 0; b < NB; b++)
            for (int c = 0; c < CPB; c++) begin
                exp_tx[b*CPB + c]             = seq_a[b];
                exp_tx[FRAME + 1 + b*CPB + c] = seq_b[b];
            end
        exp_tx[FRAME]         = 1'b1;
        exp_tx[2*FRAME + 1]   = 1'b1;
        start_word(8'h00);
        in_data = 8'hFF;                 // still valid; only the next capture sees it
        record(2*FRAME + 2, -1, 8'h00, FRAME + 1);
        in_valid = 1'b0;
        checks++;
        if (tx_t[FRAME-1:0] !== exp_tx[FRAME-1:0]) begin
            errors++;
            $display("FAIL b2b_first: tx trace=%h expected=%h", tx_t[FRAME-1:0], exp_tx[FRAME-1:0]);
        end
        checks++;
        if (tx_t[FRAME] !== 1'b1 || tx_t[FRAME+1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: idle_tx=%b next_start_tx=%b expected=1,0", tx_t[FRAME], tx_t[FRAME+1]);
        end
        checks++;
        if (tx_t !== exp_tx) begin
            errors++;
            $display("FAIL b2b_second: tx trace=%h expected=%h", tx_t, exp_tx);
        end
        exp_done = (128'd1 << (FRAME - 1)) | (128'd1 << (2*FRAME));
        checks++;
        if (done_t !== exp_done) begin
            errors++;
            $display("FAIL b2b_done: tx_done trace=%h expected=%h", done_t, exp_done);
        end
        exp_rdy = (128'd1 << FRAME) | (128'd1 << (2*FRAME + 1));
        checks++;
        if (rdy_t !== exp_rdy) begin
            errors++;
            $display("FAIL b2b_ready: ready trace=%h expected=%h", rdy_t, exp_rdy);
        end
        $display("test_back_to_back: words 00 then ff with one idle cycle checked");
    endtask

    task automatic test_ignore_busy;
        logic [11:0]  seq;
        logic [127:0] exp_tx;
        logic [127:0] exp_busy;
        logic [127:0] exp_done;
        seq    = frame_bits(8'h81, 1'b0);
        exp_tx = '0;
        for (int i = 0; i < FRAME + 6; i++) exp_tx[i] = 1'b1;
        for (int b = 0; b < NB; b++)
            for (int c = 0; c < CPB; c++)
                exp_tx[b*CPB + c] = seq[b];
        start_word(8'h81);
        in_valid = 1'b0;
        // Offer 3c across one edge in the middle of data bit 3.
        record(FRAME + 6, CPB + 3*CPB + 1, 8'h3C, -1);
        checks++;
        if (tx_t !== exp_tx) begin
            errors++;
            $display("FAIL ignore_frame: tx trace=%h expected=%h", tx_t, exp_tx);
        end
        exp_busy = (128'd1 << FRAME) - 128'd1;
        checks++;
        if (busy_t !== exp_busy) begin
            errors++;
            $display("FAIL ignore_busy: busy trace=%h expected=%h", busy_t, exp_busy);
        end
        exp_done = 128'd1 << (FRAME - 1);
        checks++;
        if (done_t !== exp_done) begin
            errors++;
            $display("FAIL ignore_done: tx_done trace=%h expected=%h", done_t, exp_done);
        end
        $display("test_ignore_busy: 81 sent unchanged while 3c offered");
    endtask

    task automatic test_reset_mid_frame;
        logic [11:0]  seq;
        logic [127:0] exp_tx;
        logic [127:0] exp_done;
        start_word(8'h6C);               // data bit 4 of 6c is 0
        in_valid = 1'b0;
        record(CPB + 4*CPB + 2, -1, 8'h00, -1);
        checks++;
        if ({tx, busy} !== 2'b01) begin
            errors++;
            $display("FAIL midframe_pre: tx/busy=%b expected=01 during data bit 4", {tx, busy});
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({tx, busy, in_ready, tx_done} !== 4'b1000) begin
            errors++;
            $display("FAIL midframe_abort: tx/busy/ready/done=%b expected=1000 before any edge", {tx, busy, in_ready, tx_done});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seq    = frame_bits(8'hC3, 1'b0);
        exp_tx = '0;
        for (int b = 0; b < NB; b++)
            for (int c = 0; c < CPB; c++)
                exp_tx[b*CPB + c] = seq[b];
        exp_tx[FRAME] = 1'b1;
        start_word(8'hC3);
        in_valid = 1'b0;
        record(FRAME + 1, -1, 8'h00, -1);
        checks++;
        if (tx_t !== exp_tx) begin
            errors++;
            $display("FAIL midframe_next: tx trace=%h expected=%h", tx_t, exp_tx);
        end
        exp_done = 128'd1 << (FRAME - 1);
        checks++;
        if (done_t !== exp_done) begin
            errors++;
            $display("FAIL midframe_done: tx_done trace=%h expected=%h", done_t, exp_done);
        end
        $display("test_reset_mid_frame: abort then word c3 checked");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_parity();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
